pipe_rca_adder: RTL
===================

// Module: pipe_rca_adder
// PURPOSE
//  Parametrised pipelined ripple-carry adder/subtractor; successor to the single-bit full adder cell.
//  WIDTH-bit operands split into CHUNK-bit slices, one slice per pipeline stage; carry registered between stages.
//  Valid/ready handshake on both sides; drops into ALU datapaths needing 64-bit add at high clock rates.
// PARAMETERS
//  WIDTH   64  operand/sum width in bits; must be an integer multiple of CHUNK
//  CHUNK   16  bits added per stage; STAGES = WIDTH/CHUNK (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (ignored when sub=1)
//  sub        in   1      1: sum = a - b (b inverted, carry-in forced 1); 0: sum = a + b + cin
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//  ovf        out  1      signed overflow (present only with PIPE_ADD_OVF_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): all stage valid bits, skew/deskew regs, sum, cout, ovf, out_valid -> 0 immediately.
//    Any beats in flight are discarded; no partial result appears after release.
//  - Accept when in_valid && in_ready. Transfer out when out_valid && out_ready.
//  - Advance enable adv = !out_valid || out_ready; in_ready = adv (combinational from out_ready).
//    When adv=0 every stage holds (registers, valid bits, carries frozen); no bubbles inserted, no beat lost.
//  - Stage k (0..STAGES-1) adds slice k of a and b' (b' = sub ? ~b : b) with carry from stage k-1
//    (stage 0 uses sub ? 1 : cin). Upper slices travel through skew regs; finished lower slices through
//    deskew regs so all slices of one beat emerge together.
//  - Latency: exactly STAGES cycles from accept to out_valid with out_ready held 1.
//    Throughput 1 beat/cycle. STAGES=1 degenerates to one registered adder.
//  - Bubbles: stage with valid=0 still clocks data but result is don't-care; out_valid follows last-stage valid.
//  - Arithmetic modulo 2^WIDTH; cout = carry out of bit WIDTH-1 of final stage. sub/cin captured per beat,
//    so mixed add/sub beats back-to-back are independent.
//  - Simultaneous out transfer and in accept with pipe full: allowed, stays full.
//  - Outputs sum/cout/ovf stable while out_valid=1 and out_ready=0.
// CONFIGURATION
//  PIPE_ADD_OVF_EN defined: ovf port exists; ovf = carry into MSB XOR carry out of MSB, aligned with sum.
//  PIPE_ADD_OVF_EN undefined: ovf port and its pipeline bits absent; all other behaviour identical.
// TESTING
//  1 WIDTH=64,CHUNK=16: a=FFFF_FFFF_FFFF_FFFF,b=1,cin=0,sub=0 -> after 4 cycles sum=0,cout=1 (carry crosses all stages).
//  2 sub=1: a=5,b=7 -> sum=FFFF_FFFF_FFFF_FFFE,cout=0; a=7,b=5 -> sum=2,cout=1.
//  3 Stream 100 random beats, out_ready=1 -> out_valid on cycles 4..103, results match model, in order.
//  4 Fill pipe, drop out_ready for 5 cycles -> in_ready=0, sum held, no loss/duplication after resume.
//  5 rst_n=0 mid-stream with 3 beats in flight -> out_valid=0 same cycle; after release, no stale output.
//  6 PIPE_ADD_OVF_EN: a=7FFF_FFFF_FFFF_FFFF,b=1 add -> ovf=1; a=8000_0000_0000_0000,b=1 sub -> ovf=1; a=1,b=1 -> ovf=0.

Source files
------------

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage, valid/ready on both sides.
// Optional signed-overflow output is enabled by defining PIPE_ADD_OVF_EN.
module pipe_rca_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = WIDTH / CHUNK;

  // Per-stage registers: opa/opb carry the not-yet-added upper slices (skew),
  // res accumulates the finished lower slices (deskew).
  logic [WIDTH-1:0] opa_r [STAGES];
  logic [WIDTH-1:0] opb_r [STAGES];
  logic [WIDTH-1:0] res_r [STAGES];
  logic [STAGES-1:0] cy_r;
  logic [STAGES-1:0] vld_r;

  logic [WIDTH-1:0] stg_a_s [STAGES];
  logic [WIDTH-1:0] stg_b_s [STAGES];
  logic [WIDTH-1:0] stg_r_s [STAGES];
  logic [STAGES-1:0] stg_c_s;
  logic [STAGES-1:0] stg_v_s;
  logic [CHUNK:0]    slice_s [STAGES];
  logic [WIDTH-1:0]  res_s   [STAGES];
  logic [STAGES-1:0] cy_s;
  logic              adv;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_r[STAGES-1];
  assign sum       = res_r[STAGES-1];
  assign cout      = cy_r[STAGES-1];

  // Stage inputs: stage 0 from the ports (b inverted and carry forced for subtract), others from the previous stage.
  always_comb begin
    stg_a_s[0] = a;
    stg_b_s[0] = sub ? ~b : b;
    stg_r_s[0] = {WIDTH{1'b0}};
    stg_c_s[0] = sub ? 1'b1 : cin;
    stg_v_s[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      stg_a_s[k] = opa_r[k-1];
      stg_b_s[k] = opb_r[k-1];
      stg_r_s[k] = res_r[k-1];
      stg_c_s[k] = cy_r[k-1];
      stg_v_s[k] = vld_r[k-1];
    end
  end

  // Slice adders: stage k adds bits [k*CHUNK +: CHUNK] and merges them into the travelling result.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slice_s[k] = {1'b0, stg_a_s[k][k*CHUNK +: CHUNK]}
                 + {1'b0, stg_b_s[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, stg_c_s[k]};
      res_s[k] = stg_r_s[k];
      res_s[k][k*CHUNK +: CHUNK] = slice_s[k][CHUNK-1:0];
      cy_s[k] = slice_s[k][CHUNK];
    end
  end

  // Pipeline registers: whole pipe advances together, or freezes together under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        opa_r[k] <= {WIDTH{1'b0}};
        opb_r[k] <= {WIDTH{1'b0}};
        res_r[k] <= {WIDTH{1'b0}};
      end
      cy_r  <= {STAGES{1'b0}};
      vld_r <= {STAGES{1'b0}};
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        opa_r[k] <= stg_a_s[k];
        opb_r[k] <= stg_b_s[k];
        res_r[k] <= res_s[k];
      end
      cy_r  <= cy_s;
      vld_r <= stg_v_s;
    end
  end

`ifdef PIPE_ADD_OVF_EN
  logic ovf_r;
  assign ovf = ovf_r;

  // Signed overflow: operands agree in sign but the result sign differs (== carry-in XOR carry-out of MSB).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (adv) begin
      ovf_r <= (stg_a_s[STAGES-1][WIDTH-1] ~^ stg_b_s[STAGES-1][WIDTH-1])
             & (slice_s[STAGES-1][CHUNK-1] ^ stg_a_s[STAGES-1][WIDTH-1]);
    end
  end
`endif

endmodule
